// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetch and MEM data access onto one req/ack memory port.
// Data wins; the global stall holds until every request this pipeline cycle is served.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_i_done, r_d_done;
  logic               r_mem_req, r_mem_we, r_err;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata, r_if_rdata, r_dm_rdata;

  logic               w_dm_req, w_d_pend, w_i_pend, w_stall, w_to, w_fin;
  logic [DATA_W-1:0]  w_cap;

  assign w_dm_req = dm_read_i | dm_write_i;
  assign w_d_pend = w_dm_req & ~r_d_done;
  assign w_i_pend = if_req_i & ~r_i_done;
  assign w_stall  = w_d_pend | w_i_pend;
  // Forced completion on the TIMEOUT-th busy cycle without an ack.
  assign w_to     = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_fin    = mem_ack_i | w_to;
  assign w_cap    = mem_ack_i ? mem_rdata_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      // Pipeline advances on any non-stalled edge, so the next requests are new.
      if (!w_stall) begin
        r_i_done <= 1'b0;
        r_d_done <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_d_pend) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= dm_write_i;
            r_mem_addr  <= dm_addr_i;
            r_mem_wdata <= dm_wdata_i;
            r_cnt       <= '0;
            r_state     <= BUSY_D;
          end else if (w_i_pend) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr_i;
            r_cnt       <= '0;
            r_state     <= BUSY_I;
          end
        end
        BUSY_D, BUSY_I: begin
          if (w_fin) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
            if (!mem_ack_i) r_err <= 1'b1;
            if (r_state == BUSY_D) begin
              r_d_done <= 1'b1;
              if (!r_mem_we) r_dm_rdata <= w_cap;
            end else begin
              r_i_done   <= 1'b1;
              r_if_rdata <= w_cap;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall_o     = w_stall;
  assign if_ready_o  = r_i_done;
  assign dm_ready_o  = r_d_done;
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign err_o       = r_err;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency backing memory between the pipeline's instruction fetch (IF stage) and data access (MEM stage). It serialises the two requesters onto a req/ack memory port, with data access taking priority. It raises a global pipeline stall until every request presented in the current pipeline cycle has been served. Registered read data is held stable for the stalled stages.

## Interface
Parameters:
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 32, data width
- TIMEOUT, 64, max cycles `mem_req_o` waits for `mem_ack_i` before forced completion (≥2)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- if_req_i  in  1  instruction fetch request
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction, registered
- if_ready_o  out  1  fetch served this pipeline cycle
- dm_read_i  in  1  data read request
- dm_write_i  in  1  data write request
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_rdata_o  out  DATA_W  load data, registered
- dm_ready_o  out  1  data access served this pipeline cycle
- stall_o  out  1  global pipeline stall (PC, IFID, IDEX, EXMEM, MEMWB hold)
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  1 = write, registered
- mem_addr_o  out  ADDR_W  registered
- mem_wdata_o  out  DATA_W  registered
- mem_rdata_i  in  DATA_W  valid in the cycle `mem_ack_i` = 1
- mem_ack_i  in  1  one-cycle completion pulse
- err_o  out  1  sticky timeout flag

## Operation
- Data request: `dm_req = dm_read_i | dm_write_i`. If both are high, the access is a write.
- Done flags `i_done` and `d_done` record requests already served in the current pipeline cycle. `if_ready_o = i_done`, `dm_ready_o = d_done`.
- `stall_o = (if_req_i & ~i_done) | (dm_req & ~d_done)`, combinational.
- On any edge with `stall_o` = 0, both done flags clear, because the pipeline advances and the next requests are new.
- FSM states:
  - IDLE: if `dm_req & ~d_done`, load the data access into the mem_* registers and go to BUSY_D. Otherwise, if `if_req_i & ~i_done`, load the fetch (`mem_we_o` = 0) and go to BUSY_I. Otherwise stay in IDLE.
  - BUSY_D / BUSY_I: hold `mem_req_o`, `mem_addr_o`, `mem_we_o` and `mem_wdata_o` stable.
    - On `mem_ack_i`: capture `mem_rdata_i` into `dm_rdata_o` or `if_rdata_o` (writes leave `dm_rdata_o` unchanged), set the matching done flag, drop `mem_req_o`, return to IDLE.
- Timeout counter:
  - Cleared on entry to BUSY, incremented each BUSY cycle without ack.
  - At TIMEOUT, the access completes as if acked with read data 0. `err_o` is set and stays set until reset.
- `mem_ack_i` in IDLE is ignored.
- Requesters hold address and data stable while `stall_o` = 1. This is guaranteed by the stall.
- Read data outputs hold their value until overwritten by a later completion.

## Timing
- Reset values:
  - FSM in IDLE.
  - `mem_req_o`, `mem_we_o`, `err_o`, `if_ready_o`, `dm_ready_o` = 0.
  - `mem_addr_o`, `mem_wdata_o`, `if_rdata_o`, `dm_rdata_o` = 0.
  - Done flags and timeout counter = 0.
  - `stall_o` follows its equation, so it is 1 if a request is present.
- Single access, request seen in IDLE at cycle N:
  - `mem_req_o` is high from N+1.
  - With ack at cycle M ≥ N+1: read data and ready are visible at M+1, `stall_o` is low at M+1, and `mem_req_o` is low at M+1.
  - Minimum stall is 2 cycles.
- Both requests in the same cycle:
  - The data access is served first.
  - The fetch is issued in the IDLE cycle after the data ack; `mem_req_o` is low for exactly one cycle between them.
  - `stall_o` stays high until the fetch completes.
  - Result visibility: `dm_ready_o` = 1 and stable from data completion, `if_ready_o` from fetch completion.
- There is no back-to-back issue without the intervening IDLE cycle.
- Reset mid-transaction: at the next edge the access is abandoned and `mem_req_o` = 0. A late ack is ignored.

## Test plan
- Fetch only, ack 1 cycle after `mem_req_o` rises, addr 0x00000010, rdata 0x8C010004:
  - `stall_o` is high 2 cycles.
  - `if_rdata_o` = 0x8C010004 with `if_ready_o` = 1 in cycle 3.
  - `mem_we_o` = 0.
- Simultaneous fetch (0x14) and load (0x100 → 0xDEADBEEF), each ack 2 cycles:
  - The memory sees 0x100 first, then 0x14.
  - There is one idle cycle between the two requests.
  - `dm_rdata_o` = 0xDEADBEEF stays held through the fetch.
  - `stall_o` drops only after the fetch ack.
- Store 0x12345678 to 0x20, with `dm_read_i` and `dm_write_i` both high:
  - `mem_we_o` = 1, `mem_wdata_o` = 0x12345678.
  - `dm_rdata_o` is unchanged.
- Ack never arrives, TIMEOUT = 4:
  - `mem_req_o` drops after 4 BUSY cycles.
  - `if_rdata_o` = 0 and `err_o` = 1, which persists until `rst_i`.
- `rst_i` pulsed while in BUSY_D, followed by a stray ack:
  - All outputs are at their reset values.
  - The stray ack causes no capture.
- Two consecutive pipeline cycles of fetch requests:
  - The done flags clear when `stall_o` = 0.
  - The second fetch is issued and correctly stalls again.
